if_stage: RTL and testbench

Instruction-fetch stage of the 5-stage RV32I pipeline. It owns the program counter and the instruction-memory request/response handshake, and it drives the IF/ID pipeline register. It sits directly upstream of decode and consumes the hazard-control outputs (`PCWrite`, `IFID_RegWrite`, `InstrFlush`) together with `BranchCtrl` and the branch targets from EX. A one-entry hold buffer absorbs a memory response that returns while IF/ID is stalled.

---
 rtl/pipe_pkg.sv | 10 +
 rtl/if_hold_buf.sv | 32 +++
 rtl/if_stage.sv | 105 ++++++++++
 tb/tb_if_stage.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and constants for the RV32I pipeline stages
package pipe_pkg;
  typedef enum logic [1:0] {PC4 = 2'b00, PCIMM = 2'b01, IMMRS1 = 2'b10} branch_ctrl_e;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  typedef enum logic [1:0] {FETCH, WAIT, KILL} if_state_e;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_entry_t;
endpackage

// File: rtl/if_hold_buf.sv
// if_hold_buf: one-entry {pc, instr} buffer that parks a fetch response while IF/ID is stalled
module if_hold_buf
  import pipe_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_i,
  input  logic        rd_i,
  input  logic        clr_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] instr_i,
  output logic        full_o,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o
);
  if_entry_t entry_q;
  logic      full_q;
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      full_q  <= 1'b0;
      entry_q <= '0;
    end else if (wr_i) begin
      full_q  <= 1'b1;
      entry_q <= '{pc: pc_i, instr: instr_i};
    end else if (rd_i) begin
      full_q  <= 1'b0;
    end
  end
  assign full_o  = full_q;
  assign pc_o    = entry_q.pc;
  assign instr_o = entry_q.instr;
endmodule

// File: rtl/if_stage.sv
// if_stage: RV32I instruction fetch with single-outstanding memory handshake and IF/ID register.
// Optional performance counters are enabled with IF_PERF_CNT_EN.
module if_stage
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  BranchCtrl,
  input  logic [31:0] pc_imm,
  input  logic [31:0] imm_rs1,
  input  logic        PCWrite,
  input  logic        IFID_RegWrite,
  input  logic        InstrFlush,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ack,
  input  logic        im_rvalid,
  input  logic [31:0] im_rdata,
  output logic [31:0] IFID_pc,
  output logic [31:0] IFID_instr,
  output logic        IFID_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] if_bubble_cnt,
  output logic [31:0] if_redirect_cnt
`endif
);
  if_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d, req_pc_q, req_pc_d;
  logic [31:0] ifid_pc_q, ifid_pc_d, ifid_instr_q, ifid_instr_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic        redirect, resp_ok, accept, bubble, keep;
  logic        hold_full;
  logic [31:0] hold_pc, hold_instr, target;
  assign redirect = BranchCtrl != PC4;
  assign target   = (BranchCtrl == IMMRS1) ? (imm_rs1 & ~32'h1) : pc_imm;
  assign resp_ok  = (state_q == WAIT) && im_rvalid && !redirect;
  assign im_req   = !rst && !redirect && PCWrite && !hold_full &&
                    (state_q == FETCH || (state_q == WAIT && im_rvalid && IFID_RegWrite));
  assign im_addr  = pc_q & ~32'h3;
  assign accept   = im_req && im_ack;
  assign bubble   = !InstrFlush && IFID_RegWrite && !hold_full && !resp_ok;
  assign keep     = !InstrFlush && !IFID_RegWrite;
  if_hold_buf u_hold (
    .clk     (clk),
    .rst     (rst),
    .wr_i    (resp_ok && !IFID_RegWrite),
    .rd_i    (!InstrFlush && IFID_RegWrite && hold_full),
    .clr_i   (redirect),
    .pc_i    (req_pc_q),
    .instr_i (im_rdata),
    .full_o  (hold_full),
    .pc_o    (hold_pc),
    .instr_o (hold_instr)
  );
  // A response arriving in WAIT or KILL always retires the outstanding request
  always_comb begin
    pc_d         = redirect ? target : accept ? pc_q + 32'd4 : pc_q;
    req_pc_d     = accept ? pc_q : req_pc_q;
    state_d      = accept ? WAIT :
                   (state_q != FETCH && im_rvalid) ? FETCH :
                   (state_q == WAIT && redirect) ? KILL : state_q;
    ifid_instr_d = (InstrFlush || bubble) ? NOP_INSTR : keep ? ifid_instr_q :
                   hold_full ? hold_instr : im_rdata;
    ifid_valid_d = (InstrFlush || bubble) ? 1'b0 : keep ? ifid_valid_q : 1'b1;
    ifid_pc_d    = (InstrFlush || bubble || keep) ? ifid_pc_q :
                   hold_full ? hold_pc : req_pc_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      req_pc_q     <= '0;
      ifid_pc_q    <= '0;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end
  assign IFID_pc    = ifid_pc_q;
  assign IFID_instr = ifid_instr_q;
  assign IFID_valid = ifid_valid_q;
`ifdef IF_PERF_CNT_EN
  logic [31:0] bubble_cnt_q, redirect_cnt_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt_q   <= '0;
      redirect_cnt_q <= '0;
    end else begin
      bubble_cnt_q   <= (bubble && ~&bubble_cnt_q) ? bubble_cnt_q + 32'd1 : bubble_cnt_q;
      redirect_cnt_q <= (redirect && ~&redirect_cnt_q) ? redirect_cnt_q + 32'd1 : redirect_cnt_q;
    end
  end
  assign if_bubble_cnt   = bubble_cnt_q;
  assign if_redirect_cnt = redirect_cnt_q;
`endif
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed bench for if_stage with a latency-programmable memory returning addr as data
module tb_if_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  BranchCtrl;
  logic [31:0] pc_imm, imm_rs1;
  logic        PCWrite, IFID_RegWrite, InstrFlush;
  logic        im_req, im_ack, im_rvalid;
  logic [31:0] im_addr, im_rdata;
  logic [31:0] IFID_pc, IFID_instr;
  logic        IFID_valid;
`ifdef IF_PERF_CNT_EN
  logic [31:0] if_bubble_cnt, if_redirect_cnt;
`endif
  int          n_vec = 0;
  int          n_err = 0;
  int          lat = 1;
  logic        pend;
  int          cnt;
  logic [31:0] paddr;

  always #5 clk = ~clk;

  if_stage dut (
    .clk           (clk),
    .rst           (rst),
    .BranchCtrl    (BranchCtrl),
    .pc_imm        (pc_imm),
    .imm_rs1       (imm_rs1),
    .PCWrite       (PCWrite),
    .IFID_RegWrite (IFID_RegWrite),
    .InstrFlush    (InstrFlush),
    .im_req        (im_req),
    .im_addr       (im_addr),
    .im_ack        (im_ack),
    .im_rvalid     (im_rvalid),
    .im_rdata      (im_rdata),
    .IFID_pc       (IFID_pc),
    .IFID_instr    (IFID_instr),
    .IFID_valid    (IFID_valid)
`ifdef IF_PERF_CNT_EN
    ,
    .if_bubble_cnt   (if_bubble_cnt),
    .if_redirect_cnt (if_redirect_cnt)
`endif
  );

  assign im_ack    = im_req;
  assign im_rvalid = pend && cnt == 0;
  assign im_rdata  = paddr;

  always_ff @(posedge clk) begin
    if (rst) begin
      pend  <= 1'b0;
      cnt   <= 0;
      paddr <= '0;
    end else begin
      if (pend && cnt == 0) pend <= 1'b0;
      else if (pend) cnt <= cnt - 1;
      if (im_req && im_ack) begin
        pend  <= 1'b1;
        paddr <= im_addr;
        cnt   <= lat - 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; BranchCtrl = 2'b00; pc_imm = '0; imm_rs1 = '0;
    PCWrite = 1'b1; IFID_RegWrite = 1'b1; InstrFlush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", {31'b0, im_req}, 32'd0);
    chk("rst_valid", {31'b0, IFID_valid}, 32'd0);
    chk("rst_instr", IFID_instr, 32'h13);
    chk("rst_pc", IFID_pc, 32'h0);
`ifdef IF_PERF_CNT_EN
    chk("rst_bcnt", if_bubble_cnt, 32'd0);
`endif
    rst = 1'b0; #1;
    chk("c0_req", {31'b0, im_req}, 32'd1);
    chk("c0_addr", im_addr, 32'h0);
    step();
    chk("c1_addr", im_addr, 32'h4);
    chk("c1_valid", {31'b0, IFID_valid}, 32'd0);
    step();
    chk("c2_instr", IFID_instr, 32'h0);
    chk("c2_valid", {31'b0, IFID_valid}, 32'd1);
    chk("c2_addr", im_addr, 32'h8);
    step();
    chk("c3_instr", IFID_instr, 32'h4);
    chk("c3_pc", IFID_pc, 32'h4);
    InstrFlush = 1'b1;
    step();
    InstrFlush = 1'b0; lat = 2;
    chk("flush_valid", {31'b0, IFID_valid}, 32'd0);
    chk("flush_instr", IFID_instr, 32'h13);
    chk("flush_pc", IFID_pc, 32'h4);
    step();
    chk("c5_instr", IFID_instr, 32'hC);
    chk("c5_req", {31'b0, im_req}, 32'd0);
    BranchCtrl = 2'b01; pc_imm = 32'h100;
    step();
    BranchCtrl = 2'b00; #1;
    chk("kill_req", {31'b0, im_req}, 32'd0);
    chk("kill_rvalid", {31'b0, im_rvalid}, 32'd1);
    chk("kill_valid", {31'b0, IFID_valid}, 32'd0);
    step();
    chk("tgt_req", {31'b0, im_req}, 32'd1);
    chk("tgt_addr", im_addr, 32'h100);
    chk("drop_valid", {31'b0, IFID_valid}, 32'd0);
    step();
    chk("lat2_req", {31'b0, im_req}, 32'd0);
    chk("lat2_bubble", IFID_instr, 32'h13);
    step();
    chk("lat2_addr", im_addr, 32'h104);
    chk("lat2_valid", {31'b0, IFID_valid}, 32'd0);
    step();
    chk("lat2_pc", IFID_pc, 32'h100);
    chk("lat2_instr", IFID_instr, 32'h100);
    chk("lat2_v", {31'b0, IFID_valid}, 32'd1);
`ifdef IF_PERF_CNT_EN
    chk("bcnt", if_bubble_cnt, 32'd5);
    chk("rcnt1", if_redirect_cnt, 32'd1);
`endif
    BranchCtrl = 2'b10; imm_rs1 = 32'h205;
    step();
    BranchCtrl = 2'b00; #1;
    chk("jalr_req", {31'b0, im_req}, 32'd0);
    step();
    chk("jalr_addr", im_addr, 32'h204);
    chk("jalr_reqv", {31'b0, im_req}, 32'd1);
    lat = 1;
    step();
    chk("c13_addr", im_addr, 32'h208);
    step();
    chk("c14_pc", IFID_pc, 32'h204);
    PCWrite = 1'b0; IFID_RegWrite = 1'b0; #1;
    chk("stall_req", {31'b0, im_req}, 32'd0);
    step();
    PCWrite = 1'b1; IFID_RegWrite = 1'b1; #1;
    chk("stall_pc", IFID_pc, 32'h204);
    chk("stall_instr", IFID_instr, 32'h204);
    chk("stall_valid", {31'b0, IFID_valid}, 32'd1);
    chk("full_req", {31'b0, im_req}, 32'd0);
    step();
    chk("hold_pc", IFID_pc, 32'h208);
    chk("hold_instr", IFID_instr, 32'h208);
    chk("hold_valid", {31'b0, IFID_valid}, 32'd1);
    chk("post_addr", im_addr, 32'h20C);
    BranchCtrl = 2'b11; pc_imm = 32'hFFFF_FFFC; #1;
    chk("redir_req", {31'b0, im_req}, 32'd0);
    step();
    BranchCtrl = 2'b00; #1;
    chk("wrap_addr0", im_addr, 32'hFFFF_FFFC);
    chk("wrap_req", {31'b0, im_req}, 32'd1);
    step();
    chk("wrap_addr1", im_addr, 32'h0);
    step();
    chk("wrap_pc", IFID_pc, 32'hFFFF_FFFC);
    chk("wrap_instr", IFID_instr, 32'hFFFF_FFFC);
`ifdef IF_PERF_CNT_EN
    chk("rcnt3", if_redirect_cnt, 32'd3);
`endif
    rst = 1'b1; #1;
    chk("mrst_req", {31'b0, im_req}, 32'd0);
    step();
    chk("mrst_valid", {31'b0, IFID_valid}, 32'd0);
    chk("mrst_instr", IFID_instr, 32'h13);
    chk("mrst_pc", IFID_pc, 32'h0);
`ifdef IF_PERF_CNT_EN
    chk("mrst_rcnt", if_redirect_cnt, 32'd0);
`endif
    rst = 1'b0; #1;
    chk("mrst_addr", im_addr, 32'h0);
    step();
    chk("mrst_addr4", im_addr, 32'h4);
    step();
    chk("mrst_first", IFID_instr, 32'h0);
    chk("mrst_fv", {31'b0, IFID_valid}, 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
